// File: rtl/cache_pkg.sv
// Shared geometry, state encoding and helpers for the direct-mapped,
// write-through cache controller.
package cache_pkg;

    localparam int unsigned TAG_W           = 23;
    localparam int unsigned INDEX_W         = 5;
    localparam int unsigned OFFSET_W        = 2;
    localparam int unsigned NUM_BLOCKS      = 32;
    localparam int unsigned WORDS_PER_BLOCK = 4;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BLOCK_W   = WORD_W * WORDS_PER_BLOCK;
    localparam int unsigned OFFSET_LSB = 2;
    localparam int unsigned INDEX_LSB = OFFSET_LSB + OFFSET_W;
    localparam int unsigned TAG_LSB   = INDEX_LSB + INDEX_W;

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StFetch,
        StFill,
        StWmem
    } cache_state_e;

endpackage

// File: rtl/cache_tag_array.sv
// Tag and valid storage: one write port, asynchronous read port and a
// single-cycle clear of every valid bit.
module cache_tag_array
    import cache_pkg::*;
#(
    parameter int unsigned TagW = TAG_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_all,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TagW-1:0]    wr_tag,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TagW-1:0]    rd_tag
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [TagW-1:0]       tag_q [NUM_BLOCKS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (clear_all) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tags are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index] <= wr_tag;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped write-through cache controller: read-allocate,
// no-write-allocate, with hit/miss statistics; data storage is external.
module cache_controller
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned STAT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [WORD_W-1:0]   cpu_wdata,
    output logic                cpu_ready,
    output logic [WORD_W-1:0]   cpu_rdata,
    input  logic                inv_all,
    output logic                cache_read_en,
    output logic                cache_write_en,
    output logic                cache_hit,
    output logic                cache_miss,
    output logic [INDEX_W-1:0]  cache_index,
    output logic [OFFSET_W-1:0] cache_offset,
    output logic [BLOCK_W-1:0]  cache_fill,
    output logic [WORD_W-1:0]   cache_wdata,
    input  logic [WORD_W-1:0]   cache_dout,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]   mem_wdata,
    input  logic [BLOCK_W-1:0]  mem_rdata,
    input  logic                mem_ack,
    output logic [STAT_W-1:0]   hit_cnt,
    output logic [STAT_W-1:0]   miss_cnt
);

    localparam int unsigned TagW = ADDR_W - TAG_LSB;

    cache_state_e state_q, state_d;

    logic [ADDR_W-1:0]  addr_q;
    logic               we_q;
    logic [WORD_W-1:0]  wdata_q;
    logic [BLOCK_W-1:0] block_q;
    logic               relookup_q;
    logic [STAT_W-1:0]  hit_cnt_q;
    logic [STAT_W-1:0]  miss_cnt_q;

    logic [INDEX_W-1:0] index;
    logic [TagW-1:0]    tag;
    logic               line_valid;
    logic [TagW-1:0]    line_tag;
    logic               lookup_hit;
    logic               tag_wr;
    logic               tag_clear;
    logic               accept;
    logic               first_lookup;

    assign index        = addr_q[INDEX_LSB +: INDEX_W];
    assign tag          = addr_q[TAG_LSB +: TagW];
    assign lookup_hit   = line_valid && (line_tag == tag);
    assign tag_wr       = (state_q == StFill);
    assign tag_clear    = (state_q == StIdle) && inv_all && !cpu_req;
    assign accept       = (state_q == StIdle) && cpu_req;
    // The lookup following a fill is a replay, not a new access.
    assign first_lookup = (state_q == StCompare) && !relookup_q;

    cache_tag_array #(
        .TagW (TagW)
    ) u_tag_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_all (tag_clear),
        .wr_en     (tag_wr),
        .wr_index  (index),
        .wr_tag    (tag),
        .rd_index  (index),
        .rd_valid  (line_valid),
        .rd_tag    (line_tag)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            block_q    <= '0;
            relookup_q <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= cpu_addr;
                we_q    <= cpu_we;
                wdata_q <= cpu_wdata;
            end
            if ((state_q == StFetch) && mem_ack) begin
                block_q <= mem_rdata;
            end
            if (state_q == StIdle) begin
                relookup_q <= 1'b0;
            end else if (state_q == StFill) begin
                relookup_q <= 1'b1;
            end
            if (first_lookup) begin
                if (lookup_hit) begin
                    hit_cnt_q <= hit_cnt_q + STAT_W'(1);
                end else begin
                    miss_cnt_q <= miss_cnt_q + STAT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        cpu_ready      = 1'b0;
        cpu_rdata      = '0;
        cache_read_en  = 1'b0;
        cache_write_en = 1'b0;
        cache_hit      = 1'b0;
        cache_miss     = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    state_d = StCompare;
                end
            end
            StCompare: begin
                if (we_q) begin
                    // Write-through: update the line only when present.
                    if (lookup_hit) begin
                        cache_write_en = 1'b1;
                        cache_hit      = 1'b1;
                    end
                    state_d = StWmem;
                end else if (lookup_hit) begin
                    cache_read_en = 1'b1;
                    cache_hit     = 1'b1;
                    cpu_ready     = 1'b1;
                    cpu_rdata     = cache_dout;
                    state_d       = StIdle;
                end else begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                mem_req  = 1'b1;
                mem_addr = {addr_q[ADDR_W-1:INDEX_LSB], {INDEX_LSB{1'b0}}};
                if (mem_ack) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                cache_write_en = 1'b1;
                cache_miss     = 1'b1;
                state_d        = StCompare;
            end
            StWmem: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_ack) begin
                    cpu_ready = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign cache_index  = index;
    assign cache_offset = addr_q[OFFSET_LSB +: OFFSET_W];
    assign cache_fill   = block_q;
    assign cache_wdata  = wdata_q;
    assign hit_cnt      = hit_cnt_q;
    assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_cache_controller.sv
// Directed plus randomized bench for cache_controller, checked against an
// abstract cache/memory model; the data array and memory are modelled here.
module tb_cache_controller;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic         cpu_ready;
    logic [31:0]  cpu_rdata;
    logic         inv_all;
    logic         cache_read_en;
    logic         cache_write_en;
    logic         cache_hit;
    logic         cache_miss;
    logic [4:0]   cache_index;
    logic [1:0]   cache_offset;
    logic [127:0] cache_fill;
    logic [31:0]  cache_wdata;
    logic [31:0]  cache_dout;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ack;
    logic [15:0]  hit_cnt;
    logic [15:0]  miss_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_controller #(
        .ADDR_W (32),
        .STAT_W (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_ready      (cpu_ready),
        .cpu_rdata      (cpu_rdata),
        .inv_all        (inv_all),
        .cache_read_en  (cache_read_en),
        .cache_write_en (cache_write_en),
        .cache_hit      (cache_hit),
        .cache_miss     (cache_miss),
        .cache_index    (cache_index),
        .cache_offset   (cache_offset),
        .cache_fill     (cache_fill),
        .cache_wdata    (cache_wdata),
        .cache_dout     (cache_dout),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
    );

    // External data array driven by the controller's strobes
    logic [31:0] dp [32][4];
    assign cache_dout = dp[cache_index][cache_offset];
    always @(posedge clk) begin
        if (cache_write_en && cache_miss) begin
            for (int w = 0; w < 4; w++) dp[cache_index][w] <= cache_fill[32*w +: 32];
        end else if (cache_write_en && cache_hit) begin
            dp[cache_index][cache_offset] <= cache_wdata;
        end
    end

    // env_mem: what the DUT wrote to memory; ref_mem: what the CPU intended
    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    bit          ref_valid [32];
    logic [22:0] ref_tag [32];
    logic [15:0] ref_hits;
    logic [15:0] ref_misses;

    function automatic logic [31:0] seed_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : seed_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : seed_word(a);
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
        ref_hits   = '0;
        ref_misses = '0;
    endtask

    task automatic do_invalidate();
        @(posedge clk); #1;
        inv_all = 1'b1;
        @(posedge clk); #1;
        inv_all = 1'b0;
        for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int lat, output logic [31:0] rdata);
        logic [31:0] wa;
        logic [31:0] exp_rdata;
        logic [31:0] first_addr;
        logic [31:0] first_wdata;
        logic [22:0] tg;
        logic        exp_hit;
        logic        first_we;
        int          idx;
        int          cyc;
        int          ready_cyc;
        int          ack_cyc;
        int          req_cycles;
        int          acks;
        bit          done;
        bit          seen_req;
        bit          extra_req;
        bit          addr_moved;
        bit          rdata_leak;
        bit          wen_seen;
        bit          wr_hit_seen;
        bit          fill_seen;
        bit          ren_seen;
        bit          ready_with_ack;

        wa  = {addr[31:2], 2'b00};
        idx = int'(addr[8:4]);
        tg  = addr[31:9];
        exp_hit = ref_valid[idx] && (ref_tag[idx] == tg);
        if (exp_hit) ref_hits++;
        else ref_misses++;
        if (we) begin
            ref_mem[wa] = wdata;
            exp_rdata   = '0;
        end else begin
            exp_rdata = ref_rd(wa);
            if (!exp_hit) begin
                ref_valid[idx] = 1'b1;
                ref_tag[idx]   = tg;
            end
        end

        rdata = '0; first_addr = '0; first_wdata = '0; first_we = 1'b0;
        cyc = 0; ready_cyc = 0; ack_cyc = 0; req_cycles = 0; acks = 0;
        done = 0; seen_req = 0; extra_req = 0; addr_moved = 0; rdata_leak = 0;
        wen_seen = 0; wr_hit_seen = 0; fill_seen = 0; ren_seen = 0; ready_with_ack = 0;

        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        while (!done && cyc < 40) begin
            mem_ack = 1'b0;
            if (mem_req) begin
                if (acks > 0) extra_req = 1;
                if (!seen_req) begin
                    seen_req = 1; first_we = mem_we; first_addr = mem_addr;
                    first_wdata = mem_wdata;
                end else if (mem_addr !== first_addr) begin
                    addr_moved = 1;
                end
                req_cycles++;
                if (req_cycles > lat && acks == 0) begin
                    mem_ack = 1'b1;
                    if (mem_we) env_mem[mem_addr] = mem_wdata;
                    else mem_rdata = {env_rd(mem_addr + 12), env_rd(mem_addr + 8),
                                      env_rd(mem_addr + 4), env_rd(mem_addr)};
                end
            end
            @(negedge clk);
            cyc++;
            if (mem_ack) begin acks++; ack_cyc = cyc; end
            if (cache_write_en) wen_seen = 1;
            if (cache_write_en && cache_hit) wr_hit_seen = 1;
            if (cache_write_en && cache_miss) fill_seen = 1;
            if (cache_read_en) ren_seen = 1;
            if (!cpu_ready && cpu_rdata !== 32'h0) rdata_leak = 1;
            if (cpu_ready) begin
                done = 1; ready_cyc = cyc; rdata = cpu_rdata; ready_with_ack = mem_ack;
            end
            @(posedge clk); #1;
        end
        cpu_req = 1'b0;
        mem_ack = 1'b0;

        check("ready_seen", done, 1);
        if (!we) check("rdata", rdata, exp_rdata);
        if (!we && exp_hit) begin
            check("hit_latency", ready_cyc - 1, 1);
            check("hit_no_mem_req", seen_req, 0);
            check("hit_read_en", ren_seen, 1);
        end
        if (!we && !exp_hit) begin
            check("miss_mem_we", first_we, 0);
            check("miss_mem_addr", first_addr, {addr[31:4], 4'h0});
            check("miss_fill", fill_seen, 1);
            check("miss_latency_bound", (ready_cyc - ack_cyc) <= 3, 1);
        end
        if (we) begin
            check("wr_mem_we", first_we, 1);
            check("wr_mem_addr", first_addr, addr);
            check("wr_mem_wdata", first_wdata, wdata);
            check("wr_ready_with_ack", ready_with_ack, 1);
            check("wr_cache_we", wen_seen, exp_hit);
            check("wr_cache_hit", wr_hit_seen, exp_hit);
        end
        check("mem_acks", acks, (we || !exp_hit) ? 1 : 0);
        check("mem_req_dropped", extra_req, 0);
        check("mem_addr_stable", addr_moved, 0);
        check("rdata_zero_idle", rdata_leak, 0);
        check("hit_cnt", hit_cnt, ref_hits);
        check("miss_cnt", miss_cnt, ref_misses);
    endtask

    initial begin
        logic [31:0] rd;
        bit          found;

        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        inv_all = 1'b0; mem_rdata = '0; mem_ack = 1'b0; found = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        check("rst_cache_we", cache_write_en, 0);

        for (int w = 0; w < 4; w++) begin
            env_mem[32'h10 + 4 * w] = 32'h1111_1111 * (w + 1);
            ref_mem[32'h10 + 4 * w] = 32'h1111_1111 * (w + 1);
        end

        access(1'b0, 32'h0000_0010, 32'h0, 2, rd);
        check("first_read_data", rd, 32'h1111_1111);
        check("first_read_miss_cnt", miss_cnt, 1);

        access(1'b0, 32'h0000_0014, 32'h0, 2, rd);
        check("reread_data", rd, 32'h2222_2222);
        check("reread_hit_cnt", hit_cnt, 1);

        access(1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 1, rd);
        access(1'b0, 32'h0000_0014, 32'h0, 1, rd);
        check("write_hit_readback", rd, 32'hDEAD_BEEF);

        access(1'b1, 32'h0000_0210, 32'h0BAD_F00D, 3, rd);
        access(1'b0, 32'h0000_0010, 32'h0, 1, rd);
        check("write_miss_keeps_line", hit_cnt, 4);

        do_invalidate();
        access(1'b0, 32'h0000_0010, 32'h0, 2, rd);
        check("inv_refetch_miss_cnt", miss_cnt, 3);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            a = ({$urandom_range(2, 0)} << 9) | ({$urandom_range(7, 0)} << 4)
                | ({$urandom_range(3, 0)} << 2);
            if ($urandom_range(24, 0) == 0) do_invalidate();
            access($urandom_range(2, 0) == 0, a, $urandom, int'($urandom_range(3, 0)), rd);
        end

        // Reset while a block fetch is outstanding, then a stray ack
        do_invalidate();
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0020;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (mem_req) found = 1;
            else begin @(posedge clk); #1; end
        end
        check("fetch_reached", found, 1);
        @(posedge clk); #1;
        rst_n = 1'b0; cpu_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = {4{32'hFFFF_0000}};
        @(negedge clk);
        check("midfetch_rst_mem_req", mem_req, 0);
        check("midfetch_rst_ready", cpu_ready, 0);
        check("midfetch_rst_miss_cnt", miss_cnt, 0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_ignored_req", mem_req, 0);
        check("late_ack_ignored_ready", cpu_ready, 0);
        model_reset();
        access(1'b0, 32'h0000_0010, 32'h0, 2, rd);
        check("post_rst_miss_cnt", miss_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
